rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Byte-stream boot loader between the UART receiver/transmitter and the instruction ROM write port.
- Parses a framed download, issues one ROM erase, then writes little-endian 32-bit words at incrementing word addresses.
- Verifies an 8-bit checksum, returns a one-byte status over the UART TX path, and holds the CPU in reset for the whole download.

Parameters:
- BASE_ADDR, 32'h0000_0000, ROM byte address of word 0.
- MAX_WORDS, 4096, largest accepted frame length in words.
- TIMEOUT_CYC, 500_000, idle cycles between bytes before abort (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid_i  in  1  one-cycle pulse: rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- tx_ready_i  in  1  UART transmitter can accept a byte.
- tx_valid_o  out  1  status byte valid.
- tx_data_o  out  8  status byte.
- rom_erase_en_o  out  1  one-cycle ROM erase pulse.
- rom_wr_en_o  out  1  one-cycle ROM word write strobe.
- rom_wr_addr_o  out  32  ROM byte address for the write.
- rom_wr_data_o  out  32  ROM write data.
- cpu_hold_o  out  1  high while a download is in progress; ANDed into the core reset.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; all outputs, counters and the checksum go to 0. Reset mid-download abandons the frame with no response; partially written ROM content is not restored.
- Frame format: 0xA5, LEN_L, LEN_H (16-bit word count), 4*LEN data bytes (LSB of each word first), then CSUM = 8-bit modulo-256 sum of the data bytes only.
- State IDLE: non-0xA5 bytes are ignored. 0xA5 goes to LEN0.
- State LEN0: captures LEN_L and goes to LEN1.
- State LEN1: captures LEN_H.
  - If LEN > MAX_WORDS, go to RESP with status 0x45, with no erase.
  - Otherwise go to ERASE.
- State ERASE: lasts exactly one cycle with rom_erase_en_o=1. It then goes to DATA, or to CSUM if LEN==0. A byte arriving during ERASE is accepted as data byte 0.
- State DATA: bytes shift into a 4-byte assembler and are added to the checksum.
  - On the 4th byte of a word, the following cycle drives rom_wr_en_o=1 with rom_wr_addr_o = BASE_ADDR + 4*word_idx and rom_wr_data_o = {b3,b2,b1,b0}. Latency is 1 cycle from that byte's rx_valid_i.
  - word_idx is 16 bits and increments after each write.
  - After word LEN-1 is written, go to CSUM.
  - rom_wr_addr_o and rom_wr_data_o are don't-care when rom_wr_en_o=0.
- State CSUM: the next byte is compared with the running sum. Go to RESP with status 0x4F on match, 0x45 on mismatch.
- State RESP: tx_valid_o=1 with tx_data_o stable until the cycle tx_ready_i=1. The next cycle is IDLE with tx_valid_o=0. rx bytes received in RESP are ignored.
- Timeout: in LEN0, LEN1, DATA and CSUM, a cycle counter clears on every rx_valid_i. When it reaches TIMEOUT_CYC, go to RESP with status 0x54.
- cpu_hold_o: registered. It is 1 in every state except IDLE, rises the cycle after 0xA5 is accepted, and falls the cycle after the RESP handshake.
- At most one of rom_erase_en_o and rom_wr_en_o is high in any cycle.

Test Plan:
- Frame A5 02 00 11 22 33 44 55 66 77 88 64 -> exactly one erase pulse, then writes (0x0,0x44332211) and (0x4,0x88776655), each 1 cycle after its 4th byte; tx 0x4F; cpu_hold_o drops after the handshake.
- Same frame with CSUM 0x65 -> both writes still occur; tx 0x45.
- A5 00 00 00 -> one erase pulse, no writes, tx 0x4F. Preceding bytes 00 FF 5A in IDLE -> no effect, cpu_hold_o stays 0.
- With MAX_WORDS=4, send A5 05 00 -> no erase, no writes, tx 0x45; the following data bytes are ignored in IDLE.
- With TIMEOUT_CYC=100, send A5 01 00 11 then silence -> tx 0x54 exactly 100 cycles after the last byte. Holding tx_ready_i low for 10 cycles -> tx_valid_o and tx_data_o stay stable.
- Assert rst_n low mid-DATA -> all outputs 0 in the same cycle with no clock edge needed. After release, a fresh valid frame completes normally with writes starting at BASE_ADDR.

Source files
------------

// File: rtl/rom_loader.sv
// Framed UART boot loader: parses A5/LEN/data/CSUM, erases the ROM once, writes
// little-endian words, and answers with a one-byte status while holding the CPU.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 4096,
    parameter int          TIMEOUT_CYC = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_ready_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        rom_erase_en_o,
    output logic        rom_wr_en_o,
    output logic [31:0] rom_wr_addr_o,
    output logic [31:0] rom_wr_data_o,
    output logic        cpu_hold_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_ERASE, S_DATA, S_CSUM, S_RESP} state_t;

    state_t      r_state;
    logic [7:0]  r_len_l;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_asm;
    logic [7:0]  r_sum;
    logic [TW-1:0] r_tmo;
    logic        r_tx_valid, r_erase, r_wr_en, r_hold;
    logic [7:0]  r_tx_data;
    logic [31:0] r_wr_addr, r_wr_data;

    logic [15:0] w_len;
    logic        w_timed, w_tmo_hit, w_data_byte, w_csum_byte, w_last_word;

    assign w_len       = {rx_data_i, r_len_l};
    assign w_timed     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_tmo_hit   = w_timed && !rx_valid_i && (r_tmo == TW'(TIMEOUT_CYC - 1));
    // The ERASE cycle already accepts the first byte of the payload (or the checksum for LEN==0).
    assign w_data_byte = rx_valid_i && ((r_state == S_DATA) || (r_state == S_ERASE && r_len != 16'd0));
    assign w_csum_byte = rx_valid_i && ((r_state == S_CSUM) || (r_state == S_ERASE && r_len == 16'd0));
    assign w_last_word = (r_word_idx == r_len - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len_l    <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_bcnt     <= '0;
            r_asm      <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_erase    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_erase <= 1'b0;
            r_wr_en <= 1'b0;
            r_tmo   <= (!w_timed || rx_valid_i) ? '0 : r_tmo + 1'b1;

            if (w_data_byte) begin
                r_sum  <= r_sum + rx_data_i;
                r_asm  <= {rx_data_i, r_asm[23:8]};
                r_bcnt <= r_bcnt + 2'd1;
                if (r_bcnt == 2'd3) begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                    r_wr_data  <= {rx_data_i, r_asm};
                    r_word_idx <= r_word_idx + 16'd1;
                end
            end

            case (r_state)
                S_IDLE: if (rx_valid_i && rx_data_i == 8'hA5) begin
                    r_state    <= S_LEN0;
                    r_hold     <= 1'b1;
                    r_sum      <= '0;
                    r_bcnt     <= '0;
                    r_word_idx <= '0;
                end
                S_LEN0: if (w_tmo_hit) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1; r_tx_data <= 8'h54;
                end else if (rx_valid_i) begin
                    r_len_l <= rx_data_i;
                    r_state <= S_LEN1;
                end
                S_LEN1: if (w_tmo_hit) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1; r_tx_data <= 8'h54;
                end else if (rx_valid_i) begin
                    r_len <= w_len;
                    if ({16'd0, w_len} > 32'(MAX_WORDS)) begin
                        r_state <= S_RESP; r_tx_valid <= 1'b1; r_tx_data <= 8'h45;
                    end else begin
                        r_state <= S_ERASE;
                        r_erase <= 1'b1;
                    end
                end
                S_ERASE: if (r_len != 16'd0) begin
                    r_state <= S_DATA;
                end else if (w_csum_byte) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1;
                    r_tx_data <= (rx_data_i == r_sum) ? 8'h4F : 8'h45;
                end else begin
                    r_state <= S_CSUM;
                end
                S_DATA: if (w_tmo_hit) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1; r_tx_data <= 8'h54;
                end else if (w_data_byte && r_bcnt == 2'd3 && w_last_word) begin
                    r_state <= S_CSUM;
                end
                S_CSUM: if (w_tmo_hit) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1; r_tx_data <= 8'h54;
                end else if (w_csum_byte) begin
                    r_state <= S_RESP; r_tx_valid <= 1'b1;
                    r_tx_data <= (rx_data_i == r_sum) ? 8'h4F : 8'h45;
                end
                S_RESP: if (tx_ready_i) begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                    r_hold     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_valid_o     = r_tx_valid;
    assign tx_data_o      = r_tx_data;
    assign rom_erase_en_o = r_erase;
    assign rom_wr_en_o    = r_wr_en;
    assign rom_wr_addr_o  = r_wr_addr;
    assign rom_wr_data_o  = r_wr_data;
    assign cpu_hold_o     = r_hold;
endmodule

// File: tb/tb_rom_loader.sv
// Directed scoreboard bench for rom_loader with small MAX_WORDS / TIMEOUT_CYC.
module tb_rom_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tx_ready_i = 1'b1;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        rom_erase_en_o;
    logic        rom_wr_en_o;
    logic [31:0] rom_wr_addr_o;
    logic [31:0] rom_wr_data_o;
    logic        cpu_hold_o;

    rom_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(4), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .tx_ready_i(tx_ready_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .rom_erase_en_o(rom_erase_en_o), .rom_wr_en_o(rom_wr_en_o),
        .rom_wr_addr_o(rom_wr_addr_o), .rom_wr_data_o(rom_wr_data_o),
        .cpu_hold_o(cpu_hold_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int erase_cnt = 0;
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write strobe and every status handshake pops an expectation.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        logic [7:0]  t;
        if (rst_n) begin
            if (rom_wr_en_o) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", rom_wr_addr_o, e[63:32]);
                    chk("wr_data", rom_wr_data_o, e[31:0]);
                end
            end
            if (rom_erase_en_o) begin
                erase_cnt++;
                chk("erase_wr_excl", 32'(rom_wr_en_o), 32'd0);
            end
            if (tx_valid_o && tx_ready_i) begin
                chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    t = exp_tx.pop_front();
                    chk("tx_byte", 32'(tx_data_o), 32'(t));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic exp_wr_now);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk);
        #1 rx_valid_i = 1'b0;
        @(negedge clk);
        chk("wr_latency", 32'(rom_wr_en_o), 32'(exp_wr_now));
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
        exp_wr.push_back({addr, w});
        send(w[7:0], 1'b0);
        send(w[15:8], 1'b0);
        send(w[23:16], 1'b0);
        send(w[31:24], 1'b1);
    endtask

    function automatic logic [7:0] csum2(input logic [31:0] a, input logic [31:0] b);
        return a[7:0] + a[15:8] + a[23:16] + a[31:24] + b[7:0] + b[15:8] + b[23:16] + b[31:24];
    endfunction

    // Assumes tx_ready_i is high, so the status is consumed in its first cycle.
    task automatic wait_resp(input logic [7:0] st);
        int n;
        n = 0;
        exp_tx.push_back(st);
        while (!tx_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", 32'(tx_valid_o), 32'd1);
        chk("resp_hold", 32'(cpu_hold_o), 32'd1);
        @(negedge clk);
        chk("resp_tx_drop", 32'(tx_valid_o), 32'd0);
        chk("resp_hold_drop", 32'(cpu_hold_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {20'd0, tx_valid_o, tx_data_o, rom_erase_en_o, rom_wr_en_o, cpu_hold_o}, 32'd0);
        chk("reset_addr", rom_wr_addr_o, 32'd0);
        chk("reset_data", rom_wr_data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Junk bytes in IDLE
        send(8'h00, 1'b0);
        chk("idle_hold0", 32'(cpu_hold_o), 32'd0);
        send(8'hFF, 1'b0);
        send(8'h5A, 1'b0);
        chk("idle_hold1", 32'(cpu_hold_o), 32'd0);
        chk("idle_tx", 32'(tx_valid_o), 32'd0);

        // Good two-word frame
        e0 = erase_cnt;
        send(8'hA5, 1'b0);
        chk("hold_rise", 32'(cpu_hold_o), 32'd1);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        chk("erase_pulse", 32'(rom_erase_en_o), 32'd1);
        send_word(32'h0, 32'h4433_2211);
        send_word(32'h4, 32'h8877_6655);
        send(csum2(32'h4433_2211, 32'h8877_6655), 1'b0);
        wait_resp(8'h4F);
        chk("erase_count_ok", 32'(erase_cnt - e0), 32'd1);

        // Same frame, bad checksum
        e0 = erase_cnt;
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h0, 32'h4433_2211);
        send_word(32'h4, 32'h8877_6655);
        send(8'h65, 1'b0);
        wait_resp(8'h45);
        chk("erase_count_bad", 32'(erase_cnt - e0), 32'd1);

        // Empty frame
        e0 = erase_cnt;
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("erase_len0", 32'(rom_erase_en_o), 32'd1);
        send(8'h00, 1'b0);
        wait_resp(8'h4F);
        chk("erase_count_len0", 32'(erase_cnt - e0), 32'd1);

        // Oversize frame: rejected without erase, trailing bytes ignored
        e0 = erase_cnt;
        send(8'hA5, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b0);
        chk("oversize_no_erase", 32'(rom_erase_en_o), 32'd0);
        wait_resp(8'h45);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("oversize_erase_cnt", 32'(erase_cnt - e0), 32'd0);
        chk("oversize_hold", 32'(cpu_hold_o), 32'd0);
        chk("oversize_tx", 32'(tx_valid_o), 32'd0);

        // Timeout mid-DATA with back-pressure on the status byte
        @(posedge clk);
        #1 tx_ready_i = 1'b0;
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        repeat (99) @(negedge clk);
        chk("tmo_early", 32'(tx_valid_o), 32'd0);
        @(negedge clk);
        chk("tmo_valid", 32'(tx_valid_o), 32'd1);
        chk("tmo_byte", 32'(tx_data_o), 32'h54);
        exp_tx.push_back(8'h54);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("tmo_stall_valid", 32'(tx_valid_o), 32'd1);
            chk("tmo_stall_byte", 32'(tx_data_o), 32'h54);
        end
        @(posedge clk);
        #1 tx_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("tmo_tx_drop", 32'(tx_valid_o), 32'd0);
        chk("tmo_hold_drop", 32'(cpu_hold_o), 32'd0);

        // Asynchronous reset in the middle of the second word
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h0, 32'hCAFE_F00D);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        chk("pre_rst_hold", 32'(cpu_hold_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {20'd0, tx_valid_o, tx_data_o, rom_erase_en_o, rom_wr_en_o, cpu_hold_o}, 32'd0);
        chk("async_rst_addr", rom_wr_addr_o, 32'd0);
        chk("async_rst_data", rom_wr_data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fresh frame after reset restarts at BASE_ADDR
        e0 = erase_cnt;
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send_word(32'h0, 32'hDEAD_BEEF);
        send_word(32'h4, 32'h0102_0304);
        send(csum2(32'hDEAD_BEEF, 32'h0102_0304), 1'b0);
        wait_resp(8'h4F);
        chk("erase_count_post", 32'(erase_cnt - e0), 32'd1);

        repeat (3) @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
